ram_burst_reader: RTL

- Initiator-side read engine for the parameterized single-port synchronous-read RAM.
- Accepts a burst command (start address, length) and issues sequential reads on the RAM address port. Read data returns one clock after the address is latched.
- Streams the returned words out on a valid/ready interface with full backpressure and a last-beat marker.
- Sits between the RAM and any downstream consumer (checker, DMA, output formatter). Write access to the RAM is muxed outside this block.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_rd_fifo2.sv | 48 ++++
 rtl/ram_burst_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM geometry defaults, burst reader states and depth helper
//   AWIDTH_DEF / DWIDTH_DEF : default RAM address / data widths (shared with the RAM wrapper)
//   state_e                 : burst reader FSM states
//   depth_of()              : RAM depth for a given address width
package ram_pkg;
   localparam int AWIDTH_DEF = 3;
   localparam int DWIDTH_DEF = 32;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/ram_rd_fifo2.sv
// ram_rd_fifo2: 2-entry FIFO catching RAM read data for the burst reader
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   push, din      : write din at the closing edge
//   pop            : drop the head word at the closing edge
//   dout           : head word (zero after reset)
//   count          : number of stored words, 0..2
module ram_rd_fifo2
   import ram_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DWIDTH-1:0] din,
   output logic [DWIDTH-1:0] dout,
   output logic [1:0]        count
);
   logic [1:0][DWIDTH-1:0] mem_q, mem_d;
   logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]             count_q, count_d;

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mem_q <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end

   assign dout = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: sequential burst reads from a sync-read RAM, streamed out on valid/ready
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   start, start_addr, length : burst command, accepted only when idle
//   busy, done              : burst in progress / one-cycle completion pulse
//   ram_addr, ram_dout      : RAM read address (registered) and data returned one cycle later
//   out_data, out_valid, out_ready, out_last : output stream with last-beat marker
module ram_burst_reader
   import ram_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [AWIDTH-1:0] start_addr,
   input  logic [AWIDTH:0]   length,
   output logic              busy,
   output logic              done,
   output logic [AWIDTH-1:0] ram_addr,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);
   localparam int            DEPTH = depth_of(AWIDTH);
   localparam logic [AWIDTH:0] ONE = 1;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] addr_ctr_q, addr_ctr_d;
   logic [AWIDTH:0]   issue_rem_q, issue_rem_d, out_rem_q, out_rem_d;
   logic              inflight_q, inflight_d, busy_q, busy_d, done_q, done_d;
   logic [1:0]        fifo_count;
   logic [2:0]        occ;
   logic              pop, issue;

   ram_rd_fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (inflight_q),
      .pop     (pop),
      .din     (ram_dout),
      .dout    (out_data),
      .count   (fifo_count)
   );

   assign out_valid = fifo_count != 2'd0;
   // the head is always the oldest undelivered word, so out_rem==1 identifies the last beat
   assign out_last = out_valid && out_rem_q == ONE;

   always_comb begin
      pop = out_valid & out_ready;
      // words that will occupy the FIFO after this edge; keep room for the read issued now
      occ = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
      issue = state_q == READ && issue_rem_q != '0 && occ < 3'd2;
      state_d = state_q;
      addr_ctr_d = addr_ctr_q;
      issue_rem_d = issue_rem_q;
      out_rem_d = out_rem_q;
      done_d = 1'b0;
      if (state_q == IDLE && start) begin
         if (length == '0) done_d = 1'b1;
         else begin
            state_d = READ;
            addr_ctr_d = start_addr;
            issue_rem_d = length;
            out_rem_d = length;
         end
      end
      if (issue) begin
         addr_ctr_d = (addr_ctr_q == AWIDTH'(DEPTH - 1)) ? '0 : addr_ctr_q + AWIDTH'(1);
         issue_rem_d = issue_rem_q - ONE;
         if (issue_rem_q == ONE) state_d = DRAIN;
      end
      if (pop) out_rem_d = out_rem_q - ONE;
      if (state_q == DRAIN && pop && out_rem_q == ONE) begin
         state_d = DONE;
         done_d = 1'b1;
      end
      if (state_q == DONE) state_d = IDLE;
      inflight_d = issue;
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_ctr_q <= '0;
         issue_rem_q <= '0;
         out_rem_q <= '0;
         inflight_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_ctr_q <= addr_ctr_d;
         issue_rem_q <= issue_rem_d;
         out_rem_q <= out_rem_d;
         inflight_q <= inflight_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign ram_addr = addr_ctr_q;
endmodule
